csr_uart_rx_fifo: RTL and testbench

CSR-mapped UART receiver with a byte FIFO and interrupt output, sitting between the board's `uart_rx` pin and the pipeline's CSR bus, alongside the default CSR peripheral. It oversamples the serial line, assembles 8-bit frames, and buffers received bytes so software can poll or take an interrupt without losing characters at full baud rate. The pipeline reads one CSR address to get the status and head byte, and to pop that byte.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/byte_fifo.sv | 45 ++++
 rtl/csr_uart_rx_fifo.sv | 154 +++++++++++++++
 tb/tb_csr_uart_rx_fifo.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver FSM states, CSR bit positions and CSR modify codes.
package uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;
  typedef enum logic [2:0] {
    MOD_NONE  = 3'd0,
    MOD_WRITE = 3'd1,
    MOD_SET   = 3'd2,
    MOD_CLEAR = 3'd3
  } csr_mod_e;
  localparam int NE_BIT  = 8;
  localparam int OVR_BIT = 9;
  localparam int FE_BIT  = 10;
  localparam int IE_BIT  = 11;
  localparam int PE_BIT  = 12;
  localparam int CNT_LSB = 16;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: 2^DEPTH_LOG2-entry byte FIFO; a push into a full FIFO succeeds only if a pop frees a slot in the same cycle.
// Ports: clk, rstn (async active-low), push/pop/data_in in; head/count/full/empty out.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            data_in,
  output logic [7:0]            head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [7:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_LOG2:0] count_q, count_d;
  logic do_push, do_pop;
  assign empty = count_q == '0;
  assign full = count_q[DEPTH_LOG2];
  assign count = count_q;
  assign head = mem_q[rptr_q];
  always_comb begin
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    wptr_d = do_push ? wptr_q + DEPTH_LOG2'(1) : wptr_q;
    rptr_d = do_pop ? rptr_q + DEPTH_LOG2'(1) : rptr_q;
    count_d = (do_push & ~do_pop) ? count_q + (DEPTH_LOG2+1)'(1) :
              (do_pop & ~do_push) ? count_q - (DEPTH_LOG2+1)'(1) : count_q;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wptr_q] <= data_in;
endmodule

// File: rtl/csr_uart_rx_fifo.sv
// csr_uart_rx_fifo: oversampling UART receiver feeding a byte FIFO, read/popped through one CSR, with rx interrupt.
// Ports: clk, rstn (async active-low), CSR bus read/modify/wdata/addr in, rdata/valid out; rx serial in; irq_rx out.
// Build option: define UART_RX_PARITY_EN for 8E1 frames with parity-error flag; default is 8N1.
module csr_uart_rx_fifo
  import uart_pkg::*;
#(
  parameter logic [11:0] CSR_ADDR   = 12'hBC3,
  parameter int          CLOCK_RATE = 200_000_000,
  parameter int          BAUD_RATE  = 115200,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        rx,
  output logic        irq_rx
);
  localparam int DIV = CLOCK_RATE / BAUD_RATE;
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  logic s1_q, s2_q;
  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic perr_q, perr_d;
  logic ie_q, ie_d, ovr_q, ovr_d, fe_q, fe_d, pe_q, pe_d;
  logic push, fe_set, pe_set, pop, expire;
  logic sel_wr, sel_set, sel_clr;
  logic [2:0] w1c;
  logic [7:0] head;
  logic [DEPTH_LOG2:0] count;
  logic full, empty;
  logic unused_wdata;
  assign unused_wdata = ^{wdata[31:13], wdata[8:0]};
  assign expire = cnt_q == '0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q - CW'(1);
    bit_d = bit_q;
    shift_d = shift_q;
    perr_d = perr_q;
    push = 1'b0;
    fe_set = 1'b0;
    pe_set = 1'b0;
    case (state_q)
      ST_IDLE: if (!s2_q) begin
        state_d = ST_START;
        cnt_d = HALF;
      end
      // Mid-start-bit recheck rejects glitches shorter than half a bit.
      ST_START: if (expire) begin
        state_d = s2_q ? ST_IDLE : ST_DATA;
        cnt_d = FULL;
        bit_d = '0;
        perr_d = 1'b0;
      end
      ST_DATA: if (expire) begin
        shift_d = {s2_q, shift_q[7:1]};
        bit_d = bit_q + 3'd1;
        cnt_d = FULL;
`ifdef UART_RX_PARITY_EN
        if (bit_q == 3'd7) state_d = ST_PARITY;
`else
        if (bit_q == 3'd7) state_d = ST_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (expire) begin
        state_d = ST_STOP;
        cnt_d = FULL;
        perr_d = s2_q ^ (^shift_q);
        pe_set = perr_d;
      end
`endif
      // Back to IDLE at mid-stop so the next start bit is caught early.
      ST_STOP: if (expire) begin
        state_d = ST_IDLE;
        push = s2_q & ~perr_q;
        fe_set = ~s2_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .push(push),
    .pop(pop),
    .data_in(shift_q),
    .head(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  assign valid = addr == CSR_ADDR;
  assign pop = read & valid & ~empty;
  assign irq_rx = ie_q & ~empty;
  always_comb begin
    sel_wr = valid & (modify == MOD_WRITE);
    sel_set = valid & (modify == MOD_SET);
    sel_clr = valid & (modify == MOD_CLEAR);
    w1c = (sel_wr | sel_clr) ? {wdata[PE_BIT], wdata[FE_BIT], wdata[OVR_BIT]} : 3'b000;
    ie_d = sel_wr ? wdata[IE_BIT] : sel_set ? (ie_q | wdata[IE_BIT]) :
           sel_clr ? (ie_q & ~wdata[IE_BIT]) : ie_q;
    ovr_d = (ovr_q & ~w1c[0]) | (push & full & ~pop);
    fe_d = (fe_q & ~w1c[1]) | fe_set;
    pe_d = (pe_q & ~w1c[2]) | pe_set;
  end
  always_comb begin
    rdata = '0;
    if (valid) begin
      rdata[7:0] = empty ? 8'h00 : head;
      rdata[NE_BIT] = ~empty;
      rdata[OVR_BIT] = ovr_q;
      rdata[FE_BIT] = fe_q;
      rdata[IE_BIT] = ie_q;
      rdata[PE_BIT] = pe_q;
      rdata[CNT_LSB +: DEPTH_LOG2+1] = count;
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      perr_q <= 1'b0;
      ie_q <= 1'b0;
      ovr_q <= 1'b0;
      fe_q <= 1'b0;
      pe_q <= 1'b0;
    end else begin
      s1_q <= rx;
      s2_q <= s1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      perr_q <= perr_d;
      ie_q <= ie_d;
      ovr_q <= ovr_d;
      fe_q <= fe_d;
      pe_q <= pe_d;
    end
endmodule

// File: tb/tb_csr_uart_rx_fifo.sv
// tb_csr_uart_rx_fifo: scoreboard bench for the CSR UART receiver FIFO at DIV=16, depth 16.
module tb_csr_uart_rx_fifo;
  localparam logic [11:0] CSR = 12'hBC3;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic read = 1'b0;
  logic rx = 1'b1;
  logic [2:0] modify = 3'd0;
  logic [31:0] wdata = '0;
  logic [11:0] addr = CSR;
  logic [31:0] rdata;
  logic valid, irq_rx;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic m_ovr = 1'b0, m_fe = 1'b0, m_pe = 1'b0, m_ie = 1'b0;
  always #5 clk = ~clk;
  csr_uart_rx_fifo #(
    .CSR_ADDR(CSR),
    .CLOCK_RATE(16),
    .BAUD_RATE(1),
    .DEPTH_LOG2(4)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .read(read),
    .modify(modify),
    .wdata(wdata),
    .addr(addr),
    .rdata(rdata),
    .valid(valid),
    .rx(rx),
    .irq_rx(irq_rx)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  function automatic logic [31:0] model_word();
    logic [31:0] w;
    w = '0;
    w[7:0] = exp_q.size() != 0 ? exp_q[0] : 8'h00;
    w[8] = exp_q.size() != 0;
    w[9] = m_ovr;
    w[10] = m_fe;
    w[11] = m_ie;
    w[12] = m_pe;
    w[20:16] = 5'(exp_q.size());
    return w;
  endfunction
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bit_phase(input logic v);
    rx = v;
    idle(16);
  endtask
  task automatic send_byte(input logic [7:0] d, input logic stop = 1'b1,
                           input logic bad_par = 1'b0, input logic pop_mid = 1'b0);
    logic ok;
    bit_phase(1'b0);
    for (int i = 0; i < 8; i++) bit_phase(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_phase((^d) ^ bad_par);
    ok = stop & ~bad_par;
    if (bad_par) m_pe = 1'b1;
`else
    ok = stop;
`endif
    if (pop_mid) begin
      rx = stop;
      idle(10);
      check("pre_pop", rdata, model_word());
      read = 1'b1;
      idle(1);
      read = 1'b0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      idle(5);
    end else bit_phase(stop);
    rx = 1'b1;
    if (!stop) m_fe = 1'b1;
    if (ok) begin
      if (exp_q.size() < 16) exp_q.push_back(d);
      else m_ovr = 1'b1;
    end
  endtask
  task automatic csr_read(input string tag);
    check(tag, rdata, model_word());
    read = 1'b1;
    idle(1);
    read = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask
  task automatic csr_mod(input logic [2:0] code, input logic [31:0] d);
    modify = code;
    wdata = d;
    idle(1);
    modify = 3'd0;
    wdata = '0;
    if (code == 3'd1) m_ie = d[11];
    if (code == 3'd2) m_ie = m_ie | d[11];
    if (code == 3'd3) m_ie = m_ie & ~d[11];
    if (code == 3'd1 || code == 3'd3) begin
      m_ovr = m_ovr & ~d[9];
      m_fe = m_fe & ~d[10];
      m_pe = m_pe & ~d[12];
    end
  endtask
  initial begin
    #2 rstn = 1'b0;
    idle(3);
    addr = 12'h000;
    #1;
    check("rst_unsel", rdata, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'h0);
    addr = CSR;
    #1;
    check("rst_sel", rdata, 32'h0);
    check("rst_irq", {31'b0, irq_rx}, 32'h0);
    rstn = 1'b1;
    idle(4);
    check("post_rst", rdata, model_word());
    send_byte(8'hA5);
    check("a5_lit", rdata, 32'h0001_01A5);
    csr_read("a5_read");
    check("a5_after", rdata, 32'h0);
    csr_read("empty_read");
    check("empty_after", rdata, 32'h0);
    for (int i = 0; i < 17; i++) send_byte(8'(i));
    check("fill_lit", rdata, 32'h0010_0300);
    for (int i = 0; i < 16; i++) csr_read($sformatf("drain%0d", i));
    check("ovr_kept", rdata, model_word());
    csr_mod(3'd1, 32'h200);
    check("ovr_clr", rdata, model_word());
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i));
    send_byte(8'h30, 1'b1, 1'b0, 1'b1);
    check("full_pushpop", rdata, model_word());
    for (int i = 0; i < 16; i++) csr_read($sformatf("drain_pp%0d", i));
    check("pp_empty", rdata, model_word());
    send_byte(8'h3C, 1'b0);
    idle(32);
    check("frame_err", rdata, model_word());
    check("frame_err_lit", rdata, 32'h0000_0400);
    csr_mod(3'd1, 32'h400);
    check("fe_clr", rdata, model_word());
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    check("glitch", rdata, model_word());
    check("glitch_lit", rdata, 32'h0);
    csr_mod(3'd2, 32'h800);
    check("ie_irq0", {31'b0, irq_rx}, 32'h0);
    check("ie_word", rdata, model_word());
    send_byte(8'h5A);
    check("irq1", {31'b0, irq_rx}, 32'h1);
    csr_read("irq_read");
    check("irq0", {31'b0, irq_rx}, 32'h0);
    send_byte(8'h11);
    send_byte(8'h22, 1'b0);
    idle(32);
    check("pre_rst_word", rdata, model_word());
    bit_phase(1'b0);
    for (int i = 0; i < 3; i++) bit_phase(1'(8'h77 >> i));
    rx = 1'b0;
    idle(8);
    rstn = 1'b0;
    rx = 1'b1;
    idle(2);
    rstn = 1'b1;
    exp_q.delete();
    m_ovr = 1'b0;
    m_fe = 1'b0;
    m_pe = 1'b0;
    m_ie = 1'b0;
    check("midrst_word", rdata, 32'h0);
    check("midrst_irq", {31'b0, irq_rx}, 32'h0);
    idle(200);
    check("midrst_nopush", rdata, model_word());
    send_byte(8'h5A);
    check("after_rst_rx", rdata, 32'h0001_015A);
    csr_read("after_rst_read");
`ifdef UART_RX_PARITY_EN
    send_byte(8'h01, 1'b1, 1'b1);
    check("par_err", rdata, model_word());
    check("par_err_lit", rdata, 32'h0000_1000);
    csr_mod(3'd1, 32'h1000);
    check("par_clr", rdata, model_word());
    send_byte(8'h03);
    check("par_ok", rdata, 32'h0001_0103);
    csr_read("par_read");
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
